// File: rtl/range_slice_pkg.sv
// Shared types and pointer arithmetic for the range-slice queue.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package range_slice_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    ERR    = 2'd2
  } slice_state_e;

  // Pointer advance modulo a power-of-two depth; callers size-cast the result.
  function automatic logic [31:0] wrap_add(input logic [31:0] ptr,
                                           input logic [31:0] off,
                                           input int unsigned depth);
    return (ptr + off) & (depth - 1);
  endfunction

endpackage

// File: rtl/slice_queue_mem.sv
// Circular buffer storage with head/tail/count and an asynchronous random read port.
// Latency: push/pop update state on the next edge; rd_data is combinational from rd_addr.
// Backpressure: push_ready drops when full; pops only when pop_enable is granted and not empty.
module slice_queue_mem
  import range_slice_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_valid,
  input  logic              pop_enable,
  output logic              pop_ready,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  head,
  output logic [IDX_W:0]    count
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  tail;
  logic              push_fire;
  logic              pop_fire;

  assign push_ready = (count != FULL_CNT);
  assign pop_ready  = (count != '0) && pop_enable;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;
  assign rd_data    = mem[rd_addr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push_fire) begin
      mem[tail] <= push_data;
    end
  end

  // Head/tail pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_fire) tail <= IDX_W'(wrap_add(32'(tail), 32'd1, DEPTH));
      if (pop_fire)  head <= IDX_W'(wrap_add(32'(head), 32'd1, DEPTH));
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/range_slice_sequencer.sv
// Queue with a range-read sequencer that streams [start,end] (head-relative) one element per cycle.
// Latency: first element the cycle after request acceptance; one element/cycle with out_ready high.
// Backpressure: out_ready=0 holds out_valid/out_data; pops blocked outside IDLE; pushes always allowed if not full.
module range_slice_sequencer
  import range_slice_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_valid,
  input  logic [DATA_W-1:0]  push_data,
  output logic               push_ready,
  input  logic               pop_valid,
  output logic               pop_ready,
  input  logic               req_valid,
  input  logic signed [31:0] req_start,
  input  logic signed [31:0] req_end,
  output logic               req_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               err_pulse,
  output logic [IDX_W:0]     q_size
);

  slice_state_e       state, state_nxt;
  logic [IDX_W-1:0]   rd_ptr;
  logic [IDX_W-1:0]   remaining;
  logic [IDX_W-1:0]   head;
  logic [IDX_W:0]     count;
  logic [DATA_W-1:0]  rd_data;
  logic               pop_enable;
  logic               req_ok;
  logic               accept;
  logic signed [31:0] count_s;

  // Head stays frozen while a slice is outstanding or being requested.
  assign pop_enable = (state == IDLE) && !req_valid;
  assign count_s    = $signed(32'(count));
  assign req_ok     = (req_start >= 0) && (req_end >= 0) &&
                      (req_start <= req_end) && (req_end < count_s);
  assign q_size     = count;
  assign out_data   = out_valid ? rd_data : '0;

  slice_queue_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_enable (pop_enable),
    .pop_ready  (pop_ready),
    .rd_addr    (rd_ptr),
    .rd_data    (rd_data),
    .head       (head),
    .count      (count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    err_pulse = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_ok) begin
            accept    = 1'b1;
            state_nxt = STREAM;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        out_last  = (remaining == '0);
        if (out_ready && out_last) state_nxt = IDLE;
      end
      ERR: begin
        err_pulse = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read pointer and remaining-element counter, snapshotted at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      remaining <= '0;
    end else if (accept) begin
      rd_ptr    <= IDX_W'(wrap_add(32'(head), req_start, DEPTH));
      remaining <= IDX_W'(req_end - req_start);
    end else if (out_valid && out_ready) begin
      rd_ptr    <= IDX_W'(wrap_add(32'(rd_ptr), 32'd1, DEPTH));
      remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: tb/tb_range_slice_sequencer.sv
// Scoreboard bench for range_slice_sequencer.
// Latency: n/a.
// Backpressure: exercises out_ready stalls, blocked pops and full-queue pushes.
module tb_range_slice_sequencer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               push_valid;
  logic [DATA_W-1:0]  push_data;
  logic               push_ready;
  logic               pop_valid;
  logic               pop_ready;
  logic               req_valid;
  logic signed [31:0] req_start;
  logic signed [31:0] req_end;
  logic               req_ready;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_last;
  logic               out_ready;
  logic               err_pulse;
  logic [IDX_W:0]     q_size;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model[$];
  logic [DATA_W:0]   sb[$];

  logic              stalled_prev = 1'b0;
  logic [DATA_W-1:0] held_data    = '0;

  always #5 clk = ~clk;

  range_slice_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .req_valid  (req_valid),
    .req_start  (req_start),
    .req_end    (req_end),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .err_pulse  (err_pulse),
    .q_size     (q_size)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every transfer, checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev <= 1'b0;
    end else begin
      if (stalled_prev && out_valid) check_eq("stall_hold", out_data, held_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", out_data, 64'hDEAD);
        end else begin
          logic [DATA_W:0] e;
          e = sb.pop_front();
          check_eq("out_data", out_data, e[DATA_W-1:0]);
          check_eq("out_last", out_last, e[DATA_W]);
        end
      end
      stalled_prev <= out_valid && !out_ready;
      held_data    <= out_data;
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic do_push(input logic [DATA_W-1:0] d);
    logic acc;
    push_valid = 1'b1;
    push_data  = d;
    @(negedge clk);
    acc = push_ready;
    check_eq("push_ready", push_ready, (model.size() < DEPTH));
    @(posedge clk); #1;
    push_valid = 1'b0;
    if (acc) model.push_back(d);
  endtask

  task automatic do_pop();
    logic acc;
    pop_valid = 1'b1;
    @(negedge clk);
    acc = pop_ready;
    check_eq("pop_ready", pop_ready, (model.size() > 0));
    @(posedge clk); #1;
    pop_valid = 1'b0;
    if (acc) void'(model.pop_front());
  endtask

  task automatic do_req(input int s, input int e);
    bit ok;
    ok = (s >= 0) && (e >= 0) && (s <= e) && (e < model.size());
    if (ok) for (int i = s; i <= e; i++) sb.push_back({(i == e), model[i]});
    req_start = s;
    req_end   = e;
    req_valid = 1'b1;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("req_ready_busy", req_ready, 0);
    if (!ok) begin
      check_eq("err_pulse", err_pulse, 1);
      check_eq("err_no_out", out_valid, 0);
      @(posedge clk); #1;
      check_eq("err_ready_back", req_ready, 1);
      check_eq("err_one_cycle", err_pulse, 0);
    end else begin
      check_eq("stream_valid", out_valid, 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_left", sb.size(), 0);
    @(posedge clk); #1;
    check_eq("drain_idle", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; push_valid = 1'b0; push_data = '0; pop_valid = 1'b0;
    req_valid = 1'b0; req_start = 0; req_end = 0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_push_ready", push_ready, 1);
    check_eq("rst_pop_ready", pop_ready, 0);
    check_eq("rst_q_size", q_size, 0);
    check_eq("rst_err", err_pulse, 0);
    check_eq("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic slice
    do_push(5); do_push(7); do_push(9); do_push(11);
    check_eq("q_size_4", q_size, 4);
    out_ready = 1'b1;
    do_req(1, 2);
    wait_drain();
    check_eq("q_size_after_slice", q_size, 4);
    do_req(0, 3);
    wait_drain();

    // Rejected requests
    do_req(2, 1);
    do_req(0, 4);
    do_req(-1, 0);
    check_eq("q_size_after_err", q_size, 4);

    // Fill, wrap the tail, full-queue slice
    for (int i = 0; i < 12; i++) do_push(32'h100 + i);
    check_eq("full_q_size", q_size, 16);
    check_eq("full_push_ready", push_ready, 0);
    do_push(32'h999);
    for (int i = 0; i < 3; i++) do_pop();
    for (int i = 0; i < 3; i++) do_push(32'h200 + i);
    do_req(0, 15);
    wait_drain();

    // Stall pattern with a blocked pop
    for (int i = 0; i < 4; i++) do_pop();
    begin
      int pat[6] = '{1, 0, 0, 1, 1, 1};
      out_ready = 1'b0;
      do_req(0, 3);
      for (int i = 0; i < 6; i++) begin
        out_ready = pat[i][0];
        pop_valid = (i == 1);
        @(negedge clk);
        if (i == 1) check_eq("pop_blocked", pop_ready, 0);
        @(posedge clk); #1;
      end
      pop_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      check_eq("q_size_after_stall", q_size, model.size());
    end

    // Push during a single-element stream
    out_ready = 1'b0;
    do_req(0, 0);
    do_push(100);
    out_ready = 1'b1;
    wait_drain();
    check_eq("q_size_push_in_stream", q_size, 13);
    check_eq("tail_value", model[12], 100);

    // Reset mid-stream
    out_ready = 1'b0;
    do_req(0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model.delete();
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_q_size", q_size, 0);
    check_eq("mid_rst_req_ready", req_ready, 1);
    check_eq("mid_rst_push_ready", push_ready, 1);
    out_ready = 1'b1;
    do_push(42);
    do_req(0, 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/range_slice_sequencer.md
Name: range_slice_sequencer

Overview:
- Circular-buffer queue holding up to DEPTH words, with a range-read sequencer on its output side.
- Producers push at the tail; a consumer pops at the head.
- A slice requester names an inclusive index range [start, end], relative to the head. The block streams those elements out one per cycle over a valid/ready handshake.
- Sits between packet/word producers and downstream slice consumers. Replaces the unbounded combinational queue-slice with bounded, sequenced hardware.

Parameters:
- DATA_W, 32, width of each queue element
- DEPTH, 16, queue capacity in elements; must be a power of two, 2 or greater
- IDX_W, $clog2(DEPTH), width of the head/tail pointers and slice indices

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- push_valid  in  1  push request
- push_data  in  DATA_W  element to append
- push_ready  out  1  queue not full
- pop_valid  in  1  discard head element
- pop_ready  out  1  pop accepted this cycle
- req_valid  in  1  slice request
- req_start  in  32  signed first index, relative to head
- req_end  in  32  signed last index, inclusive
- req_ready  out  1  FSM in IDLE
- out_valid  out  1  slice element valid
- out_data  out  DATA_W  slice element
- out_last  out  1  marks the final element of the slice
- out_ready  in  1  consumer accepts
- err_pulse  out  1  one-cycle pulse on a rejected request
- q_size  out  IDX_W+1  current occupancy

Behaviour:
- Reset: clk-synchronous, while rst=1.
  - head=0, tail=0, count=0, FSM=IDLE.
  - All outputs 0 except req_ready=1 and push_ready=1.
  - Asserting rst mid-stream aborts the slice with no out_last, and empties the queue.
- Push:
  - push_ready = (count != DEPTH).
  - On push_valid && push_ready: mem[tail] <= push_data; tail wraps mod DEPTH; count increments.
  - Pushes are legal in every FSM state.
- Pop:
  - pop_ready = (count != 0) && FSM==IDLE && !req_valid.
  - A slice request has priority over a pop in the same cycle.
  - On pop_valid && pop_ready: head wraps mod DEPTH; count decrements.
  - Simultaneous push and pop: count unchanged.
- q_size: registered count, updated the cycle after the push/pop.
- FSM, states IDLE, STREAM, ERR:
  - IDLE: req_ready=1. On req_valid, validate with 32-bit signed compares against the current count:
    - Valid when start>=0, end>=0, start<=end, and end<count.
    - Valid: latch base=(head+start) mod DEPTH and remaining=end-start, then go to STREAM.
    - Invalid: go to ERR.
  - STREAM: out_valid=1, out_data=mem[rd_ptr], out_last=(remaining==0).
    - On out_ready: rd_ptr wraps mod DEPTH and remaining decrements.
    - On a transfer with out_last=1: return to IDLE.
    - out_valid stays high and out_data stays stable while out_ready=0.
  - ERR: err_pulse=1 for exactly one cycle, out_valid=0, then IDLE.
- Latency: first element appears the cycle after request acceptance; one element per cycle under continuous out_ready.
- Slice indices are snapshotted at acceptance:
  - Head is frozen during STREAM because pops are blocked.
  - Pushes during STREAM land beyond end and never alter streamed data.
  - Push to the slot being read in the same cycle cannot occur, since that slot is occupied.
- A full-queue slice (start=0, end=DEPTH-1) must stream correctly across wrap-around.
- out_data is a combinational read of mem; the memory has no read latency.

Decomposition:
- Package range_slice_pkg:
  - FSM state enum slice_state_e {IDLE, STREAM, ERR}.
  - Helper function wrap_add(ptr, off) for mod-DEPTH pointer arithmetic.
- One natural sub-module: slice_queue_mem. It holds the storage array plus head/tail/count and push/pop logic, and exposes an arbitrary read port.
- The top module owns the FSM and the request validation.

Test Plan:
- Reset, push 5,7,9,11, request [1,2] with out_ready=1 → out_data 7 then 9, out_last on 9, q_size=4, queue unchanged.
- Request [2,1], then [0,4] with count=4, then [-1,0] → err_pulse each time, no out_valid, req_ready back to 1 the next cycle.
- Fill to DEPTH=16, pop 3, push 3 (tail wraps), request [0,15] → 16 elements in push order across the wrap; push_ready=0 while full.
- During STREAM, toggle out_ready 1,0,0,1 → out_data held stable while stalled; assert pop_valid → pop_ready=0, count unchanged.
- Push 100 during STREAM of [0,0] → streamed value is the old head; q_size increments by 1.
- Assert rst mid-STREAM → next cycle out_valid=0, q_size=0, req_ready=1, push_ready=1.
